hazard_stall_unit: RTL

- Decode-stage hazard controller that complements the EX-stage forwarding unit: it handles the hazards that bypassing cannot resolve.
- Stalls on load-use and branch-operand dependencies, flushes on taken branches, and freezes the pipeline while the data memory has not answered a request.
- Sits beside the ID stage and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB write-enable and flush controls. Holds a memory-wait FSM with timeout and saturating performance counters.

---
 rtl/hazard_stall_if.sv | 41 ++++
 rtl/hazard_stall_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_if.sv
// Control bundle between the ID-stage hazard unit and the pipeline registers it steers.
interface hazard_stall_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic [4:0]       IDEX_Dst;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [4:0]       EXMEM_Dst;
    logic             EXMEM_MemRead;
    logic             MEM_Req;
    logic             mem_ready;
    logic             EX_BranchTaken;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             Pipe_Freeze;
    logic             Mem_Error;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Freeze_Count;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, IDEX_Dst, IDEX_MemRead, IDEX_RegWrite,
               EXMEM_Dst, EXMEM_MemRead, MEM_Req, mem_ready, EX_BranchTaken,
        input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze,
               Mem_Error, Stall_Count, Freeze_Count, Flush_Count
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, IDEX_Dst, IDEX_MemRead, IDEX_RegWrite,
               EXMEM_Dst, EXMEM_MemRead, MEM_Req, mem_ready, EX_BranchTaken,
        output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze,
               Mem_Error, Stall_Count, Freeze_Count, Flush_Count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use / branch-operand stalls, taken-branch
// flushes and a memory-wait freeze FSM with timeout, plus saturating event counters.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_stall_if.slave hs
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use, br_dep, stall, freeze, flush, stall_act;

    // Register 0 is hard-wired, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    assign load_use = hs.IDEX_MemRead &&
                      reg_match(hs.IDEX_Dst, hs.ID_Rs, hs.ID_Rt, hs.ID_UsesRt);
    assign br_dep   = hs.ID_Branch &&
                      ((hs.IDEX_RegWrite && reg_match(hs.IDEX_Dst, hs.ID_Rs, hs.ID_Rt, hs.ID_UsesRt)) ||
                       (hs.EXMEM_MemRead && reg_match(hs.EXMEM_Dst, hs.ID_Rs, hs.ID_Rt, hs.ID_UsesRt)));
    assign stall    = load_use || br_dep;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        case (state_q)
            RUN: begin
                if (hs.MEM_Req && !hs.mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (hs.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) state_d = ERROR;
                    else                         wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERROR:   freeze  = 1'b1;
            default: state_d = RUN;
        endcase
    end

    assign flush     = !freeze && hs.EX_BranchTaken;
    assign stall_act = !freeze && !flush && stall;

    assign stall_cnt_d  = sat_inc(stall_cnt_q, stall_act);
    assign freeze_cnt_d = sat_inc(freeze_cnt_q, freeze);
    assign flush_cnt_d  = sat_inc(flush_cnt_q, flush);

    // Pipeline enables are held low for as long as reset is asserted.
    always_comb begin
        hs.PC_Write    = 1'b0;
        hs.IFID_Write  = 1'b0;
        hs.IDEX_Bubble = 1'b0;
        hs.IFID_Flush  = 1'b0;
        hs.IDEX_Flush  = 1'b0;
        hs.Pipe_Freeze = 1'b0;
        if (!reset) begin
            if (freeze) begin
                hs.Pipe_Freeze = 1'b1;
                hs.IDEX_Bubble = 1'b1;
            end else if (flush) begin
                hs.PC_Write   = 1'b1;
                hs.IFID_Write = 1'b1;
                hs.IFID_Flush = 1'b1;
                hs.IDEX_Flush = 1'b1;
            end else if (stall) begin
                hs.IDEX_Bubble = 1'b1;
            end else begin
                hs.PC_Write   = 1'b1;
                hs.IFID_Write = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            wait_cnt_q   <= 8'd0;
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hs.Mem_Error    = (state_q == ERROR);
    assign hs.Stall_Count  = stall_cnt_q;
    assign hs.Freeze_Count = freeze_cnt_q;
    assign hs.Flush_Count  = flush_cnt_q;
endmodule
